// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Reset/lock sequencer for the video rPLL. Holds the PLL in reset, waits for
// a synchronised lock, qualifies it for a stable window, then releases the
// downstream video reset. Lock timeout, lock loss and a software restart all
// re-sequence the PLL. Clocked from the free-running PLL reference clock.
//
// Optional build macro: PLL_LOSS_CNT_EN
//   adds loss_cnt[7:0], a saturating count of RUN exits caused by lock loss.

module pll_lock_supervisor #(
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned LOCK_STABLE  = 4096,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       timeout_err,
    output logic [3:0] retry_cnt,
    output logic [1:0] state_o
`ifdef PLL_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Terminal counts: a state lasting N cycles exits when the counter is N-1.
    localparam logic [CNT_W-1:0] L_RST_LAST     = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_lock_meta_p0;
    logic             r_lock_s_p1;
    logic             w_lock_s;

    logic             w_timeout;
    logic             r_pll_reset;
    logic             r_sys_rst_n;
    logic             r_pll_ready;
    logic             r_timeout_err;
    logic [3:0]       r_retry_cnt;

`ifdef PLL_LOSS_CNT_EN
    logic             w_loss;
    logic [7:0]       r_loss_cnt;
`endif

    // Two-flop synchroniser: the only place pll_lock is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta_p0 <= 1'b0;
            r_lock_s_p1    <= 1'b0;
        end else begin
            r_lock_meta_p0 <= pll_lock;
            r_lock_s_p1    <= r_lock_meta_p0;
        end
    end

    assign w_lock_s = r_lock_s_p1;

    // State and dwell counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode; restart overrides every other transition and
    // suppresses the timeout event so a colliding timeout is not counted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_timeout   = 1'b0;
`ifdef PLL_LOSS_CNT_EN
        w_loss      = 1'b0;
`endif
        if (restart) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == L_RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = S_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == L_TIMEOUT_LAST) begin
                        w_state_nxt = S_RESET_PLL;
                        w_cnt_nxt   = '0;
                        w_timeout   = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == L_STABLE_LAST) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    // RUN has no terminal count, so the counter is frozen.
                    w_cnt_nxt = r_cnt;
                    if (!w_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                        w_cnt_nxt   = '0;
`ifdef PLL_LOSS_CNT_EN
                        w_loss      = 1'b1;
`endif
                    end
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Registered outputs decoded from the next state: glitch-free and aligned
    // with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_reset   <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_pll_ready   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pll_reset   <= (w_state_nxt == S_RESET_PLL);
            r_sys_rst_n   <= (w_state_nxt == S_RUN);
            r_pll_ready   <= (w_state_nxt == S_RUN);
            r_timeout_err <= w_timeout;
        end
    end

    // Saturating lock-timeout counter, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry_cnt <= 4'd0;
        end else if (w_timeout && (r_retry_cnt != 4'hF)) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
        end
    end

`ifdef PLL_LOSS_CNT_EN
    // Saturating count of lock losses seen while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

    assign pll_reset   = r_pll_reset;
    assign sys_rst_n   = r_sys_rst_n;
    assign pll_ready   = r_pll_ready;
    assign timeout_err = r_timeout_err;
    assign retry_cnt   = r_retry_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a behavioural reference model
// checked every cycle, plus hand-computed dwell-time and event checks.

module tb_pll_lock_supervisor;

    localparam int RST_HOLD     = 16;
    localparam int LOCK_TIMEOUT = 100;
    localparam int LOCK_STABLE  = 8;
    localparam int CNT_W        = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       timeout_err;
    logic [3:0] retry_cnt;
    logic [1:0] state_o;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_supervisor #(
        .RST_HOLD     (RST_HOLD),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .restart     (restart),
        .pll_reset   (pll_reset),
        .sys_rst_n   (sys_rst_n),
        .pll_ready   (pll_ready),
        .timeout_err (timeout_err),
        .retry_cnt   (retry_cnt),
        .state_o     (state_o)
`ifdef PLL_LOSS_CNT_EN
        ,
        .loss_cnt    (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0..3 as reported on state_o; m_left = cycles still to spend in the
    // phase; lock history models the two-cycle synchroniser delay.
    int m_state = 0;
    int m_left  = RST_HOLD;
    int m_retry = 0;
    int m_loss  = 0;
    int m_nxt;
    bit m_to    = 1'b0;
    bit m_h0    = 1'b0;
    bit m_h1    = 1'b0;
    bit m_ls;
    bit m_reenter;

    function automatic int dwell(input int s);
        case (s)
            0:       return RST_HOLD;
            1:       return LOCK_TIMEOUT;
            2:       return LOCK_STABLE;
            default: return 0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_left = RST_HOLD; m_retry = 0; m_loss = 0;
                m_to = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
            end else begin
                m_ls      = m_h1;
                m_nxt     = m_state;
                m_to      = 1'b0;
                m_reenter = 1'b0;
                if (restart) begin
                    m_nxt = 0;
                    m_reenter = 1'b1;
                end else if (m_state == 0) begin
                    if (m_left == 1) m_nxt = 1;
                end else if (m_state == 1) begin
                    if (m_ls) m_nxt = 2;
                    else if (m_left == 1) begin
                        m_nxt = 0;
                        m_to = 1'b1;
                        if (m_retry < 15) m_retry++;
                    end
                end else if (m_state == 2) begin
                    if (!m_ls) m_nxt = 1;
                    else if (m_left == 1) m_nxt = 3;
                end else begin
                    if (!m_ls) begin
                        m_nxt = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
                if (m_reenter || (m_nxt != m_state)) m_left = dwell(m_nxt);
                else if (m_state != 3) m_left--;
                m_state = m_nxt;
                m_h1 = m_h0;
                m_h0 = pll_lock;
            end
        end
    end

    // Per-cycle comparison, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("state_o",     int'(state_o),     m_state);
            chk("pll_reset",   int'(pll_reset),   (m_state == 0) ? 1 : 0);
            chk("sys_rst_n",   int'(sys_rst_n),   (m_state == 3) ? 1 : 0);
            chk("pll_ready",   int'(pll_ready),   (m_state == 3) ? 1 : 0);
            chk("timeout_err", int'(timeout_err), int'(m_to));
            chk("retry_cnt",   int'(retry_cnt),   m_retry);
`ifdef PLL_LOSS_CNT_EN
            chk("loss_cnt",    int'(loss_cnt),    m_loss);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    // Counts consecutive falling edges (starting now) on which state_o == s.
    task automatic run_len(input logic [1:0] s, input int maxc, output int len);
        len = 0;
        while ((state_o == s) && (len < maxc)) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},     int'(state_o),     0);
        chk({tag, "_pll_reset"}, int'(pll_reset),   1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n),   0);
        chk({tag, "_ready"},     int'(pll_ready),   0);
        chk({tag, "_timeout"},   int'(timeout_err), 0);
        chk({tag, "_retry"},     int'(retry_cnt),   0);
`ifdef PLL_LOSS_CNT_EN
        chk({tag, "_loss"},      int'(loss_cnt),    0);
`endif
    endtask

    initial begin
        int len;
        int hold;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (3) @(negedge clk);

        // Clean lock from reset release.
        pll_lock = 1'b1;
        rst_n    = 1'b1;
        run_len(2'd0, 100, len); chk("t1_reset_len", len, 16);
        run_len(2'd1, 200, len); chk("t1_wait_len", len, 1);
        run_len(2'd2, 100, len); chk("t1_stable_len", len, 8);
        chk("t1_state_run", int'(state_o), 3);
        chk("t1_sys_rst_n", int'(sys_rst_n), 1);
        chk("t1_ready", int'(pll_ready), 1);
        chk("t1_retry", int'(retry_cnt), 0);

        // Lock loss in RUN: reset drops on the 3rd edge.
        repeat (3) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk); chk("t4_edge1_sys", int'(sys_rst_n), 1);
        @(negedge clk); chk("t4_edge2_sys", int'(sys_rst_n), 1);
        @(negedge clk); chk("t4_edge3_sys", int'(sys_rst_n), 0);
        chk("t4_edge3_ready", int'(pll_ready), 0);
        run_len(2'd0, 100, len); chk("t4_reset_len", len, 16);
`ifdef PLL_LOSS_CNT_EN
        chk("t4_loss", int'(loss_cnt), 1);
`endif

        // No lock: 16 timeouts, retry_cnt saturates at 15.
        for (int k = 1; k <= 16; k++) begin
            run_len(2'd1, 300, len); chk("t2_wait_len", len, 100);
            chk("t2_timeout_pulse", int'(timeout_err), 1);
            chk("t2_retry", int'(retry_cnt), (k > 15) ? 15 : k);
            run_len(2'd0, 100, len); chk("t2_reset_len", len, 16);
        end

        // Async reset mid-WAIT_LOCK.
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_wait");
        @(negedge clk);
        rst_n = 1'b1;

        // One timeout, then a lock glitch inside STABLE.
        run_len(2'd0, 100, len); chk("t3_reset_len", len, 16);
        run_len(2'd1, 300, len); chk("t3_wait_len", len, 100);
        chk("t3_retry1", int'(retry_cnt), 1);
        run_len(2'd0, 100, len); chk("t3_reset_len2", len, 16);
        pll_lock = 1'b1;
        run_len(2'd1, 300, len); chk("t3_sync_delay", len, 3);
        repeat (3) @(negedge clk);
        pll_lock = 1'b0;
        run_len(2'd2, 100, len); chk("t3_stable_cut", len, 3);
        pll_lock = 1'b1;
        run_len(2'd1, 300, len); chk("t3_rewait_len", len, 3);
        chk("t3_sys_low", int'(sys_rst_n), 0);
        run_len(2'd2, 100, len); chk("t3_stable_full", len, 8);
        chk("t3_run", int'(state_o), 3);
        chk("t3_retry_kept", int'(retry_cnt), 1);

        // Restart out of RUN: not a lock loss.
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_state", int'(state_o), 0);
        chk("rs_sys_rst_n", int'(sys_rst_n), 0);
`ifdef PLL_LOSS_CNT_EN
        chk("rs_loss", int'(loss_cnt), 0);
`endif
        run_len(2'd0, 100, len); chk("rs_reset_len", len, 16);
        run_len(2'd1, 300, len); chk("rs_wait_len", len, 1);
        run_len(2'd2, 100, len); chk("rs_stable_len", len, 8);

        // Async reset mid-RUN.
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_run");
        @(negedge clk);
        pll_lock = 1'b0;
        rst_n    = 1'b1;

        // Restart colliding with the timeout cycle.
        run_len(2'd0, 100, len); chk("t5_reset_len", len, 16);
        run_len(2'd1, 300, len); chk("t5_wait_len", len, 100);
        chk("t5_retry1", int'(retry_cnt), 1);
        run_len(2'd0, 100, len); chk("t5_reset_len2", len, 16);
        repeat (99) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("t5_coll_state", int'(state_o), 0);
        chk("t5_coll_timeout", int'(timeout_err), 0);
        chk("t5_coll_retry", int'(retry_cnt), 1);
        run_len(2'd0, 100, len); chk("t5_coll_reset_len", len, 16);

        // Restart held for 10 cycles inside RESET_PLL.
        restart = 1'b1;
        @(negedge clk);
        hold = 0;
        repeat (10) begin
            if (pll_reset) hold++;
            @(negedge clk);
        end
        restart = 1'b0;
        run_len(2'd0, 100, len);
        chk("t5_hold_reset_len", hold + len, 26);
        chk("t5_hold_retry", int'(retry_cnt), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
